alu_nibble_sequencer: RTL and testbench
=======================================

# alu_nibble_sequencer

Multi-nibble front-end for the 4-bit 74181 logic unit. Accepts a WIDTH-bit operand pair and a 4-bit function select through a valid/ready handshake. Streams the operands one nibble per cycle, LSB nibble first, into the combinational logic unit and assembles the returned nibbles into a WIDTH-bit result. Presents the result with flag bits on a second valid/ready handshake. Sits directly upstream of the logic unit and drives its s/a/b inputs while consuming its f output.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; NIB = WIDTH/4.
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  sequencer can accept a request.
- in_s  input  4  74181 function select.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- lu_s  output  4  select to logic unit.
- lu_a  output  4  A nibble to logic unit.
- lu_b  output  4  B nibble to logic unit.
- lu_f  input  4  logic unit result nibble; combinational from lu_s/lu_a/lu_b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_f  output  WIDTH  assembled result.
- out_zero  output  1  out_f == 0.
- out_eq  output  1  out_f all ones (74181 A=B convention).

## Operation
- State machine: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE
  - in_ready = 1.
  - On in_valid && in_ready: register in_s, in_a and in_b; clear idx to 0; go to RUN.
- RUN
  - lu_s = s_reg.
  - lu_a = a_reg[4*idx +: 4] and lu_b = b_reg[4*idx +: 4].
  - Each edge writes lu_f into f_reg[4*idx +: 4] and increments idx.
  - When idx == NIB-1, the edge instead goes to DONE.
  - idx is ceil(log2(NIB)) bits wide, minimum 1, and never wraps past NIB-1.
- DONE
  - out_valid = 1.
  - out_f, out_zero and out_eq hold stable until out_valid && out_ready, then go to IDLE.
- Outside RUN, lu_s, lu_a and lu_b are driven to 0.
- out_zero and out_eq are registered at the RUN→DONE edge, computed from the fully assembled result. They are not combinational from out_f.
- in_ready is 0 in RUN and DONE. Requests presented then are ignored; the sequencer neither drops nor latches them. A held in_valid is taken in the next IDLE cycle.
- Registered operands are immune to in_* changes after acceptance.
- The sequencer adds no arithmetic or carry. Nibbles are independent logic operations.

## Timing
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE, idx = 0, s_reg/a_reg/b_reg/f_reg = 0.
  - out_valid = 0, out_f = 0, out_zero = 0, out_eq = 0.
  - in_ready = 1, lu_s/lu_a/lu_b = 0.
- Reset during RUN or DONE abandons the operation; no partial result is ever presented.
- Latency: the request is accepted on edge E0. Nibble k is on lu_* during the cycle after E0+k and captured at edge E0+k+1. out_valid rises after edge E0+NIB, which is 4 cycles for WIDTH=16.
- A result handshake at edge Ed returns to IDLE, so in_ready = 1 in the following cycle. Minimum request spacing is NIB+2 cycles.
- out_ready may be high before out_valid; the handshake completes on the first DONE cycle.
- out_ready is ignored outside DONE.

## Test plan
- XOR, WIDTH=16: s=0110, a=0x1234, b=0x00FF -> out_f=0x12CB, out_zero=0, out_eq=0, out_valid 4 cycles after acceptance. Check lu_a sequence 4,3,2,1 and lu_b sequence F,F,0,0.
- Constants: s=0011 with any a/b -> out_f=0x0000, out_zero=1. s=1100 -> out_f=0xFFFF, out_eq=1, out_zero=0.
- AND with backpressure: s=1011, a=0xF0F0, b=0xFF00, out_ready low for 3 DONE cycles -> out_f=0xF000 held stable with out_valid=1 and in_ready=0 throughout. Handshake on the 4th cycle; in_ready=1 on the next cycle.
- Input stall: in_valid held high with new in_a=0xAAAA during RUN (s=1111) -> first result unaffected. Second request accepted only in IDLE after the first result handshake; second out_f=0xAAAA.
- Reset mid-operation: assert rst_n low during the 2nd RUN cycle -> immediately out_valid=0, out_f=0, lu_*=0, in_ready=1. After release, a fresh request (s=1010, b=0x5A5A) yields out_f=0x5A5A.
- Parameter sweep: WIDTH=4 and WIDTH=32 with s=1001 (XNOR), a=b -> out_f all ones, out_eq=1, with latency 1 and 8 cycles respectively.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: streams WIDTH-bit operands one nibble per cycle through a 74181 logic unit
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       lu_s,
  output logic [3:0]       lu_a,
  output logic [3:0]       lu_b,
  input  logic [3:0]       lu_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_zero,
  output logic             out_eq
);
  localparam int NIB = WIDTH / 4;
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [IW+1:0] sh;
  logic [3:0] s_reg;
  logic [WIDTH-1:0] a_reg, b_reg, f_nx;
  logic run, last;
  assign run = state == RUN;
  assign last = idx == IW'(NIB - 1);
  assign sh = {idx, 2'b00};
  // out_f doubles as the assembly register; f_nx is it with the current nibble merged in
  assign f_nx = (out_f & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(lu_f) << sh);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE)
             : state == RUN  ? (last ? DONE : RUN)
             : (out_ready ? IDLE : DONE);
    in_ready = state == IDLE;
    out_valid = state == DONE;
    lu_s = run ? s_reg : 4'd0;
    lu_a = run ? 4'(a_reg >> sh) : 4'd0;
    lu_b = run ? 4'(b_reg >> sh) : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      s_reg <= '0;
      a_reg <= '0;
      b_reg <= '0;
      out_f <= '0;
      out_zero <= 1'b0;
      out_eq <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      s_reg <= in_s;
      a_reg <= in_a;
      b_reg <= in_b;
      idx <= '0;
    end else if (run) begin
      out_f <= f_nx;
      idx <= last ? idx : idx + 1'b1;
      if (last) begin
        out_zero <= f_nx == '0;
        out_eq <= &f_nx;
      end
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: scoreboard bench with a 74181 logic-mode model and a full-width reference
module tb_alu_nibble_sequencer;
  logic clk = 0, rst_n = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero, out_eq;
  logic [3:0] in_s = 0, lu_s, lu_a, lu_b, lu_f;
  logic [15:0] in_a = 0, in_b = 0, out_f;
  logic sw_valid = 0;
  logic [3:0] sw_s = 0;
  logic [31:0] sw_a = 0;
  logic in_ready4, out_valid4, out_zero4, out_eq4, in_ready32, out_valid32, out_zero32, out_eq32;
  logic [3:0] lu_s4, lu_a4, lu_b4, lu_f4, out_f4, lu_s32, lu_a32, lu_b32, lu_f32;
  logic [31:0] out_f32;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct {logic [15:0] f; logic z; logic e; int t;} exp_t;
  exp_t sb[$];

  function automatic logic [31:0] f181(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return '0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return '1;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  assign lu_f = 4'(f181(lu_s, 32'(lu_a), 32'(lu_b)));
  assign lu_f4 = 4'(f181(lu_s4, 32'(lu_a4), 32'(lu_b4)));
  assign lu_f32 = 4'(f181(lu_s32, 32'(lu_a32), 32'(lu_b32)));

  alu_nibble_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
    .in_a(in_a), .in_b(in_b), .lu_s(lu_s), .lu_a(lu_a), .lu_b(lu_b), .lu_f(lu_f),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_zero(out_zero), .out_eq(out_eq));
  alu_nibble_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(in_ready4), .in_s(sw_s),
    .in_a(sw_a[3:0]), .in_b(sw_a[3:0]), .lu_s(lu_s4), .lu_a(lu_a4), .lu_b(lu_b4), .lu_f(lu_f4),
    .out_valid(out_valid4), .out_ready(1'b1), .out_f(out_f4), .out_zero(out_zero4), .out_eq(out_eq4));
  alu_nibble_sequencer #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(in_ready32), .in_s(sw_s),
    .in_a(sw_a), .in_b(sw_a), .lu_s(lu_s32), .lu_a(lu_a32), .lu_b(lu_b32), .lu_f(lu_f32),
    .out_valid(out_valid32), .out_ready(1'b1), .out_f(out_f32), .out_zero(out_zero32), .out_eq(out_eq32));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected event", n);
  endtask

  always @(posedge clk) cyc++;

  // Issue one request, then push its reference result; called just after a rising edge
  task automatic send(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b, input bit rnd);
    int n = 0;
    logic [15:0] r;
    in_s = s; in_a = a; in_b = b; in_valid = 1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!in_ready) begin
      timeout("accept");
      return;
    end
    @(posedge clk); #1;
    r = 16'(f181(s, 32'(a), 32'(b)));
    sb.push_back('{f: r, z: r == 16'h0, e: &r, t: cyc});
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) timeout("drain");
  endtask

  logic pv = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got out_f %h expected no result", out_f);
      end else begin
        chk("out_f", 32'(out_f), 32'(sb[0].f));
        chk("out_zero", 32'(out_zero), 32'(sb[0].z));
        chk("out_eq", 32'(out_eq), 32'(sb[0].e));
        chk("in_ready_done", 32'(in_ready), 0);
        if (!pv) chk("latency", cyc - sb[0].t, 4);
        if (out_ready) void'(sb.pop_front());
      end
    end
    pv = out_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, l4, l32;
    #1 rst_n = 0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_f", 32'(out_f), 0);
    chk("rst_flags", {out_zero, out_eq}, 0);
    chk("rst_lu", {lu_s, lu_a, lu_b}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    out_ready = 1;
    send(4'b0110, 16'h1234, 16'h00FF, 0);
    in_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lu_s_seq", 32'(lu_s), 6);
      chk("lu_a_seq", 32'(lu_a), 32'(4'(16'h1234 >> (4 * k))));
      chk("lu_b_seq", 32'(lu_b), 32'(4'(16'h00FF >> (4 * k))));
    end
    @(posedge clk); #1;
    drain();
    send(4'b0011, 16'($urandom), 16'($urandom), 0);
    in_valid = 0;
    drain();
    send(4'b1100, 16'($urandom), 16'($urandom), 0);
    in_valid = 0;
    drain();
    out_ready = 0;
    send(4'b1011, 16'hF0F0, 16'hFF00, 0);
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) timeout("bp_valid");
    repeat (2) @(negedge clk);
    chk("bp_held_valid", 32'(out_valid), 1);
    @(posedge clk); #1 out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", 32'(in_ready), 1);
    chk("bp_valid_after", 32'(out_valid), 0);
    @(posedge clk); #1;
    send(4'b1111, 16'h1234, 16'h5678, 0);
    in_a = 16'hAAAA;
    in_b = 16'($urandom);
    send(4'b1111, 16'hAAAA, in_b, 0);
    in_valid = 0;
    drain();
    send(4'b0110, 16'($urandom), 16'($urandom), 0);
    in_valid = 0;
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_f", 32'(out_f), 0);
    chk("mid_rst_lu", {lu_s, lu_a, lu_b}, 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    send(4'b1010, 16'($urandom), 16'h5A5A, 0);
    in_valid = 0;
    drain();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(4'($urandom), 16'($urandom), 16'($urandom), 1);
    end
    in_valid = 0;
    drain();
    for (int r = 0; r < 2; r++) begin
      sw_a = r == 0 ? $urandom : 32'h0;
      sw_s = 4'b1001;
      sw_valid = 1;
      chk("sw_ready4", 32'(in_ready4), 1);
      chk("sw_ready32", 32'(in_ready32), 1);
      @(posedge clk); #1 sw_valid = 0;
      l4 = -1;
      l32 = -1;
      for (int t = 1; t <= 20; t++) begin
        @(negedge clk);
        if (out_valid4 && l4 < 0) begin
          l4 = t - 1;
          chk("w4_f", 32'(out_f4), 32'hF);
          chk("w4_eq", 32'(out_eq4), 1);
        end
        if (out_valid32 && l32 < 0) begin
          l32 = t - 1;
          chk("w32_f", out_f32, 32'hFFFF_FFFF);
          chk("w32_eq", 32'(out_eq32), 1);
        end
      end
      chk("w4_latency", l4, 1);
      chk("w32_latency", l32, 8);
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
